code_bcd_dec: RTL and testbench

CODE_BCD_DEC -- requirements
Module: code_bcd_dec

---
 rtl/code_bcd_dec_if.sv | 22 ++
 rtl/code_bcd_dec.sv | 128 ++++++++++++
 tb/tb_code_bcd_dec.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_bcd_dec_if.sv
// Serial-code to BCD decoder bus: bit-serial input handshake plus the
// assembled-word output handshake and its status flags.
interface code_bcd_dec_if;
  logic        bit_in;
  logic        bit_valid;
  logic        in_ready;
  logic [15:0] bcd_out;
  logic        out_valid;
  logic        out_ready;
  logic        code_err;
  logic [7:0]  err_cnt;

  modport master (
    output bit_in, bit_valid, out_ready,
    input  in_ready, bcd_out, out_valid, code_err, err_cnt
  );

  modport slave (
    input  bit_in, bit_valid, out_ready,
    output in_ready, bcd_out, out_valid, code_err, err_cnt
  );
endinterface

// File: rtl/code_bcd_dec.sv
// Serial codeword to 4-digit BCD decoder.
// Collects 16 bits (four 4-bit codewords, MSB first), decodes each codeword
// to a BCD digit as it completes, then holds the word until the consumer
// takes it. Invalid codewords store digit 0 and raise a sticky code_err.
// Optional build macro CODE_BCD_DEC_ERR_CNT_EN enables a saturating
// invalid-codeword counter on err_cnt; otherwise err_cnt is tied to zero.
module code_bcd_dec (
  input logic          clk,
  input logic          rst,
  code_bcd_dec_if.slave bus
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t      state, state_nxt;
  // First three bits of the codeword in flight; the fourth bit is taken
  // straight from bit_in so the codeword can be decoded in its own cycle.
  logic [2:0]  prefix;
  logic [1:0]  bit_cnt;
  logic [1:0]  dig_cnt;
  logic [15:0] bcd_reg;
  logic        err_reg;
  logic        in_ready_c;
  logic        out_valid_c;
  logic        accept;
  logic        cw_done;
  logic        word_done;
  logic        xfer;
  logic [3:0]  codeword;
  logic [3:0]  digit;
  logic        invalid;

  assign accept    = bus.bit_valid && (state == COLLECT);
  assign codeword  = {prefix, bus.bit_in};
  assign cw_done   = accept && (bit_cnt == 2'd3);
  assign word_done = cw_done && (dig_cnt == 2'd3);
  assign xfer      = (state == HOLD) && bus.out_ready;

  // Map the completed codeword to its digit and flag the unused codes.
  always_comb begin
    digit   = 4'd0;
    invalid = 1'b0;
    case (codeword)
      4'b0000: digit = 4'd0;
      4'b0111: digit = 4'd1;
      4'b0110: digit = 4'd2;
      4'b0101: digit = 4'd3;
      4'b0100: digit = 4'd4;
      4'b1011: digit = 4'd5;
      4'b1010: digit = 4'd6;
      4'b1001: digit = 4'd7;
      4'b1000: digit = 4'd8;
      4'b1111: digit = 4'd9;
      default: invalid = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs: collect until the 16th bit, then hold.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      COLLECT: begin
        in_ready_c = 1'b1;
        if (word_done) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = COLLECT;
      end
    endcase
  end

  // Shift in accepted bits, store each decoded digit, and rearm on transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefix  <= 3'd0;
      bit_cnt <= 2'd0;
      dig_cnt <= 2'd0;
      bcd_reg <= 16'h0000;
      err_reg <= 1'b0;
    end else if (accept) begin
      prefix  <= codeword[2:0];
      bit_cnt <= bit_cnt + 2'd1;
      if (cw_done) begin
        case (dig_cnt)
          2'd0: bcd_reg[15:12] <= digit;
          2'd1: bcd_reg[11:8]  <= digit;
          2'd2: bcd_reg[7:4]   <= digit;
          2'd3: bcd_reg[3:0]   <= digit;
        endcase
        dig_cnt <= dig_cnt + 2'd1;
        if (invalid) err_reg <= 1'b1;
      end
    end else if (xfer) begin
      bit_cnt <= 2'd0;
      dig_cnt <= 2'd0;
      err_reg <= 1'b0;
    end
  end

`ifdef CODE_BCD_DEC_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Count invalid codewords across words, sticking at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   err_cnt_q <= 8'h00;
    else if (cw_done && invalid && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'h01;
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 8'h00;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.bcd_out   = bcd_reg;
  assign bus.code_err  = err_reg;

endmodule

// File: tb/tb_code_bcd_dec.sv
// Self-checking bench for code_bcd_dec. Expected words are computed from a
// codeword lookup table when stimulus is sent, queued, and compared when the
// decoder presents the word. Honours CODE_BCD_DEC_ERR_CNT_EN for err_cnt.
module tb_code_bcd_dec;

  typedef struct {
    logic [15:0] bcd;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   model_cnt;
  exp_t sb[$];

  // Codeword -> digit, -1 for unused codes.
  int dec_tab[16] = '{0, -1, -1, -1, 4, 3, 2, 1, 8, 7, 6, 5, -1, -1, -1, 9};

  code_bcd_dec_if bus();

  code_bcd_dec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Send 16 bits MSB first and queue the expected decoded word.
  task automatic send_word(input logic [15:0] cws, input bit gaps);
    exp_t        e;
    int          d;
    logic [3:0]  cw;
    e.bcd = 16'h0000;
    e.err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cw = cws[15-4*k -: 4];
      d  = dec_tab[cw];
      if (d < 0) begin
        e.err = 1'b1;
`ifdef CODE_BCD_DEC_ERR_CNT_EN
        if (model_cnt < 255) model_cnt++;
`endif
      end else begin
        e.bcd[15-4*k -: 4] = d[3:0];
      end
    end
    e.cnt = model_cnt[7:0];
    sb.push_back(e);

    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL word_start_in_ready: got %b expected 1", bus.in_ready);
    end
    for (int i = 15; i >= 0; i--) begin
      if (gaps) begin
        for (int g = 0; g < (i % 4); g++) begin
          bus.bit_valid = 1'b0;
          bus.bit_in    = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      if (i == 0) begin
        total++;
        if (bus.out_valid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL early_out_valid: got %b expected 0", bus.out_valid);
        end
      end
      bus.bit_valid = 1'b1;
      bus.bit_in    = cws[i];
      @(negedge clk);
    end
    bus.bit_valid = 1'b0;
  endtask

  // Wait for the word, compare against the queue, stall, then take it.
  task automatic collect_word(input string name, input int hold_cycles);
    exp_t e;
    int   waited;
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_queue: got empty scoreboard expected a word", name);
      return;
    end
    e = sb.pop_front();
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_timeout: got out_valid=%b expected 1 within 50 cycles", name, bus.out_valid);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      return;
    end
    total++;
    if (waited !== 0) begin
      bad++;
      $display("[TB] FAIL %s_latency: got %0d extra cycles expected 0", name, waited);
    end
    total++;
    if (bus.bcd_out !== e.bcd) begin
      bad++;
      $display("[TB] FAIL %s_bcd: got %h expected %h", name, bus.bcd_out, e.bcd);
    end
    total++;
    if (bus.code_err !== e.err) begin
      bad++;
      $display("[TB] FAIL %s_code_err: got %b expected %b", name, bus.code_err, e.err);
    end
    total++;
    if (bus.err_cnt !== e.cnt) begin
      bad++;
      $display("[TB] FAIL %s_err_cnt: got %0d expected %0d", name, bus.err_cnt, e.cnt);
    end
    for (int i = 0; i < hold_cycles; i++) begin
      bus.out_ready = 1'b0;
      bus.bit_valid = ~bus.bit_valid;
      bus.bit_in    = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.bcd_out !== e.bcd || bus.code_err !== e.err) begin
        bad++;
        $display("[TB] FAIL %s_hold: got valid=%b ready=%b bcd=%h err=%b expected valid=1 ready=0 bcd=%h err=%b",
                 name, bus.out_valid, bus.in_ready, bus.bcd_out, bus.code_err, e.bcd, e.err);
      end
    end
    bus.bit_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.code_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_after_xfer: got ready=%b valid=%b err=%b expected ready=1 valid=0 err=0",
               name, bus.in_ready, bus.out_valid, bus.code_err);
    end
    total++;
    if (bus.bcd_out !== e.bcd) begin
      bad++;
      $display("[TB] FAIL %s_bcd_retained: got %h expected %h", name, bus.bcd_out, e.bcd);
    end
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.out_ready = 1'b0;
    model_cnt     = 0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.bcd_out !== 16'h0000 ||
        bus.code_err !== 1'b0 || bus.err_cnt !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_state: got ready=%b valid=%b bcd=%h err=%b cnt=%0d expected 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.bcd_out, bus.code_err, bus.err_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bus.out_ready = 1'b1;
    send_word(16'h7654, 1'b0);
    collect_word("basic_1234", 0);
  endtask

  task automatic test_gaps;
    send_word(16'hF80B, 1'b1);
    collect_word("gaps_9805", 0);
  endtask

  task automatic test_invalid;
    send_word(16'h7165, 1'b0);
    collect_word("invalid_1023", 0);
  endtask

  task automatic test_hold;
    bus.out_ready = 1'b0;
    send_word(16'hBA90, 1'b0);
    collect_word("hold_5670", 5);
  endtask

  task automatic test_mid_reset;
    logic [5:0] junk;
    junk = 6'b101101;
    bus.out_ready = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = junk[i];
      @(negedge clk);
    end
    bus.bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.bcd_out !== 16'h0000 ||
          bus.code_err !== 1'b0 || bus.err_cnt !== 8'h00) begin
        bad++;
        $display("[TB] FAIL mid_reset_state: got ready=%b valid=%b bcd=%h err=%b cnt=%0d expected 1 0 0000 0 0",
                 bus.in_ready, bus.out_valid, bus.bcd_out, bus.code_err, bus.err_cnt);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    send_word(16'h4567, 1'b0);
    collect_word("mid_reset_4321", 0);
  endtask

  task automatic test_saturate;
    bus.out_ready = 1'b1;
    for (int w = 0; w < 65; w++) begin
      send_word(16'hEEEE, 1'b0);
      collect_word("saturate", 0);
    end
    total++;
`ifdef CODE_BCD_DEC_ERR_CNT_EN
    if (bus.err_cnt !== 8'd255) begin
      bad++;
      $display("[TB] FAIL saturate_final: got %0d expected 255", bus.err_cnt);
    end
`else
    if (bus.err_cnt !== 8'd0) begin
      bad++;
      $display("[TB] FAIL saturate_final: got %0d expected 0", bus.err_cnt);
    end
`endif
  endtask

  // Run every scenario in order, then report.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_invalid();
    test_hold();
    test_mid_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
